instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the 8-bit program counter register. It reads the current PC, requests the instruction word from instruction memory over a req/ack handshake and holds it in an instruction register for the decoder under a valid/ready handshake. It also computes the next PC (sequential increment or branch target) and drives the PC register's data input and count-enable, so the PC advances only when a fetched instruction is consumed or a redirect lands.

## Interface
- `AW`, 8: address/PC width; must match the PC register.
- `IW`, 16: instruction word width.
- `TIMEOUT`, 15: cycles with no ack before a fetch error; only used with `FETCH_TIMEOUT_EN`.

Ports:
- `Clk` input 1: single clock, rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `PCOut` input AW: current PC from the PC register.
- `PCNext` output AW: next PC, wired to the PC register data input.
- `PCEn` output 1: PC register count-enable, wired to the PC register's `Cen`.
- `ImemAddr` output AW: instruction memory address; always equals `PCOut`.
- `ImemReq` output 1: instruction memory request.
- `ImemAck` input 1: memory ack; `ImemData` is valid in the same cycle.
- `ImemData` input IW: instruction word from memory.
- `Instr` output IW: instruction register contents.
- `InstrValid` output 1: `Instr` is offered to the decoder.
- `InstrReady` input 1: decoder accepts `Instr`.
- `BranchTaken` input 1: one-cycle redirect pulse from execute.
- `BranchTarget` input AW: redirect address, sampled when `BranchTaken` is high.
- `FetchErr` output 1: sticky fetch-timeout flag.

## Operation
- States:
  - IDLE: reset state; all outputs low.
  - FETCH: `ImemReq` is 1.
  - ISSUE: `InstrValid` is 1 unless a redirect is present.
- IDLE → FETCH unconditionally one cycle after `Rst` is released.
- FETCH:
  - `ImemReq` stays high until `ImemAck`.
  - On ack with no pending redirect, `ImemData` is captured into `Instr` and the state moves to ISSUE. `PCEn` stays 0.
- ISSUE:
  - When `InstrValid` and `InstrReady` are both high, `PCEn` = 1 and `PCNext` = `PCOut`+1, modulo 2^AW (8'hFF → 8'h00).
  - The state then returns to FETCH.
  - Without `InstrReady`, `Instr` and `InstrValid` hold.
- Redirect in ISSUE:
  - `InstrValid` is forced to 0 in that cycle, so no transfer occurs.
  - `PCEn` = 1 and `PCNext` = `BranchTarget`; the state moves to FETCH.
- Redirect in FETCH with no ack:
  - The address must stay stable, so `BranchTarget` is latched into a pending-target register and the flush flag is set. The PC is not updated.
  - A later redirect before the ack overwrites the pending target (latest wins).
- Ack while flush is set:
  - The data is discarded.
  - `PCEn` = 1 and `PCNext` = pending target; flush is cleared and the state stays in FETCH.
- Redirect in the same cycle as ack in FETCH:
  - The data is discarded.
  - `PCEn` = 1 and `PCNext` = `BranchTarget` (the live input wins over any pending target); flush is cleared and the state stays in FETCH.
- `BranchTaken` in IDLE is ignored.
- `Rst` mid-operation:
  - Returns to IDLE and clears the instruction register, flush flag, pending target and `FetchErr`.
  - An outstanding memory request is dropped. Memory must tolerate `ImemReq` falling without an ack.

## Timing
- Reset values:
  - `Instr` = 0, `InstrValid` = 0, `ImemReq` = 0, `PCEn` = 0, `FetchErr` = 0.
  - `PCNext` = `PCOut`+1 (don't-care while `PCEn` = 0).
- Registered: state, `Instr`, flush flag, pending target, `FetchErr`, timeout counter.
- Combinational: `ImemReq`, `InstrValid` (gated by `BranchTaken`), `PCEn`, `PCNext`, `ImemAddr`.
- Latency: ack at edge N puts `Instr` valid from cycle N+1.
- Throughput: with zero-wait memory and decoder always ready, one instruction every 2 cycles.
- The PC register updates on the edge ending the cycle in which `PCEn` = 1. The next FETCH cycle therefore sees the new `PCOut`.
- `PCEn` is never asserted in IDLE, or in FETCH without an ack.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT+1)`-bit counter counts FETCH cycles without an ack and clears on entering FETCH.
  - When the count reaches `TIMEOUT`, the cycle is treated as an ack with data all-zeros (NOP), and `FetchErr` is set sticky until `Rst`.
  - A pending flush still applies: the NOP is discarded and the PC loads the pending target.
- `FETCH_TIMEOUT_EN` undefined:
  - FETCH waits indefinitely.
  - `FetchErr` is tied 0 and no counter is built.

## Test plan
- Reset and release; memory acks immediately with 16'hA001 at PC 8'h00, decoder ready → IDLE, FETCH, ISSUE. `Instr` = 16'hA001, `PCEn` pulses with `PCNext` = 8'h01.
- Memory ack delayed 3 cycles, decoder holds `InstrReady` low for 4 cycles → `ImemReq` high for 4 cycles, `Instr` stable, and `PCEn` = 0 until ready.
- `PCOut` = 8'hFF, instruction consumed → `PCNext` = 8'h00.
- `BranchTaken` in ISSUE with target 8'h40 → `InstrValid` = 0 that cycle, `PCEn` = 1 with `PCNext` = 8'h40, state FETCH.
- `BranchTaken` with target 8'h20 two cycles into a stalled FETCH, then 8'h30, then ack → data discarded, `PCEn` = 1 with `PCNext` = 8'h30.
- With `FETCH_TIMEOUT_EN` and no ack for 15 cycles → `Instr` = 16'h0000, `InstrValid` = 1 and `FetchErr` = 1 until `Rst`. Without the macro, `ImemReq` stays high and `FetchErr` stays 0.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage feeding the decoder and steering the PC register
//
// Reads the current PC, fetches the instruction word over a req/ack handshake,
// holds it for the decoder under a valid/ready handshake and drives the PC
// register's data input and count-enable.
//
// Optional feature macro: FETCH_TIMEOUT_EN (fetch timeout counter and sticky FetchErr).
//
// Ports:
//   Clk, Rst          clock (rising edge), synchronous active-high reset
//   PCOut             current PC from the PC register
//   PCNext, PCEn      next PC and count-enable to the PC register
//   ImemAddr, ImemReq instruction memory address (= PCOut) and request
//   ImemAck, ImemData memory ack and same-cycle instruction word
//   Instr, InstrValid instruction register and its valid flag to the decoder
//   InstrReady        decoder accepts Instr
//   BranchTaken       one-cycle redirect pulse from execute
//   BranchTarget      redirect address
//   FetchErr          sticky fetch-timeout flag (0 without FETCH_TIMEOUT_EN)

module instr_fetch #(
    parameter int AW      = 8,
    parameter int IW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [AW-1:0] PCOut,
    output logic [AW-1:0] PCNext,
    output logic          PCEn,
    output logic [AW-1:0] ImemAddr,
    output logic          ImemReq,
    input  logic          ImemAck,
    input  logic [IW-1:0] ImemData,
    output logic [IW-1:0] Instr,
    output logic          InstrValid,
    input  logic          InstrReady,
    input  logic          BranchTaken,
    input  logic [AW-1:0] BranchTarget,
    output logic          FetchErr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    // A timeout of zero would turn every fetch into an immediate NOP.
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("instr_fetch: TIMEOUT must be at least 1");
    end

    logic [1:0]    state;
    logic [IW-1:0] instr_q;
    logic          flush_q;
    logic [AW-1:0] pend_q;

    logic          timeout_hit;
    logic          ack_eff;
    logic [IW-1:0] fetch_word;
    logic [AW-1:0] pc_inc;

    // A timeout behaves like an ack that returns an all-zero NOP word.
    assign ack_eff    = ImemAck | timeout_hit;
    assign fetch_word = ImemAck ? ImemData : '0;
    assign pc_inc     = PCOut + {{(AW-1){1'b0}}, 1'b1};

    assign ImemAddr   = PCOut;
    assign Instr      = instr_q;

    always_comb begin
        ImemReq    = 1'b0;
        InstrValid = 1'b0;
        PCEn       = 1'b0;
        PCNext     = pc_inc;
        case (state)
            ST_FETCH: begin
                ImemReq = 1'b1;
                // The address must stay put while the request is open, so the
                // PC only moves once the memory answers; a live redirect beats
                // a pending one.
                if (ack_eff && BranchTaken) begin
                    PCEn   = 1'b1;
                    PCNext = BranchTarget;
                end else if (ack_eff && flush_q) begin
                    PCEn   = 1'b1;
                    PCNext = pend_q;
                end
            end
            ST_ISSUE: begin
                // A redirect kills the held instruction before the decoder can take it.
                InstrValid = ~BranchTaken;
                if (BranchTaken) begin
                    PCEn   = 1'b1;
                    PCNext = BranchTarget;
                end else if (InstrReady) begin
                    PCEn   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IDLE;
            instr_q <= '0;
            flush_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (ack_eff) begin
                        if (BranchTaken || flush_q) begin
                            // Wrong-path word: drop it and refetch at the new PC.
                            flush_q <= 1'b0;
                        end else begin
                            instr_q <= fetch_word;
                            state   <= ST_ISSUE;
                        end
                    end else if (BranchTaken) begin
                        // Latest redirect wins while the fetch is outstanding.
                        flush_q <= 1'b1;
                        pend_q  <= BranchTarget;
                    end
                end
                ST_ISSUE: begin
                    if (BranchTaken || InstrReady) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;
    logic          err_q;

    assign timeout_hit = (state == ST_FETCH) && !ImemAck && (to_cnt == CW'(TIMEOUT));
    assign FetchErr    = err_q;

    // Counts cycles of the current fetch attempt; any answer (real or timed
    // out) or leaving FETCH starts the next attempt from zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((state != ST_FETCH) || ack_eff) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign FetchErr    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch

module tb_instr_fetch;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  PCOut;
    logic [7:0]  PCNext;
    logic        PCEn;
    logic [7:0]  ImemAddr;
    logic        ImemReq;
    logic        ImemAck;
    logic [15:0] ImemData;
    logic [15:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic        BranchTaken;
    logic [7:0]  BranchTarget;
    logic        FetchErr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    instr_fetch #(.AW(8), .IW(16), .TIMEOUT(15)) dut (
        .Clk(Clk), .Rst(Rst), .PCOut(PCOut), .PCNext(PCNext), .PCEn(PCEn),
        .ImemAddr(ImemAddr), .ImemReq(ImemReq), .ImemAck(ImemAck), .ImemData(ImemData),
        .Instr(Instr), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .FetchErr(FetchErr)
    );

    // PC register that the fetch stage steers.
    always @(posedge Clk) begin
        if (Rst) PCOut <= 8'h00;
        else if (PCEn) PCOut <= PCNext;
    end

    typedef struct {
        logic        ack;
        logic [15:0] data;
        logic        rdy;
        logic        br;
        logic [7:0]  tgt;
        logic        req;
        logic        vld;
        logic        en;
        logic [7:0]  nxt;
        logic [15:0] ins;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 time units later.
    task automatic drive(input logic rst, input logic ack, input logic [15:0] data,
                         input logic rdy, input logic br, input logic [7:0] tgt);
        @(negedge Clk);
        Rst = rst; ImemAck = ack; ImemData = data;
        InstrReady = rdy; BranchTaken = br; BranchTarget = tgt;
        #2;
    endtask

    task automatic check_outs(input string tag, input logic req, input logic vld,
                              input logic en, input logic [7:0] nxt, input logic [15:0] ins,
                              input logic err);
        check({tag, ".req"},  {31'd0, ImemReq}, {31'd0, req});
        check({tag, ".vld"},  {31'd0, InstrValid}, {31'd0, vld});
        check({tag, ".pcen"}, {31'd0, PCEn}, {31'd0, en});
        check({tag, ".pcnext"}, {24'd0, PCNext}, {24'd0, nxt});
        check({tag, ".instr"}, {16'd0, Instr}, {16'd0, ins});
        check({tag, ".err"},  {31'd0, FetchErr}, {31'd0, err});
    endtask

    // Two reset cycles; outputs checked in the second, Rst left high.
    task automatic do_reset(input string tag);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'h00);
        check_outs(tag, 1'b0, 1'b0, 1'b0, 8'h01, 16'h0000, 1'b0);
        check({tag, ".addr"}, {24'd0, ImemAddr}, 32'h0);
    endtask

    // Reference model: the stage is either waiting on memory or holding a word
    // for the decoder, with an optional redirect remembered while waiting.
    logic        m_started, m_holding, m_redir;
    logic [7:0]  m_redir_pc, m_pc;
    logic [15:0] m_word;

    task automatic model_reset();
        m_started = 0; m_holding = 0; m_redir = 0;
        m_redir_pc = 8'h00; m_pc = 8'h00; m_word = 16'h0000;
    endtask

    task automatic model_cycle(input logic rst, input logic ack, input logic [15:0] data,
                               input logic rdy, input logic br, input logic [7:0] tgt);
        logic e_req, e_vld, e_en;
        logic [7:0] e_nxt;
        e_req = 0; e_vld = 0; e_en = 0; e_nxt = m_pc + 8'd1;
        if (m_started && !m_holding) begin
            e_req = 1;
            if (ack && br) begin e_en = 1; e_nxt = tgt; end
            else if (ack && m_redir) begin e_en = 1; e_nxt = m_redir_pc; end
        end else if (m_started) begin
            e_vld = !br;
            if (br) begin e_en = 1; e_nxt = tgt; end
            else if (rdy) e_en = 1;
        end
        check_outs("rand", e_req, e_vld, e_en, e_nxt, m_word, 1'b0);
        check("rand.addr", {24'd0, ImemAddr}, {24'd0, m_pc});
        if (rst) begin
            model_reset();
        end else begin
            if (e_en) m_pc = e_nxt;
            if (!m_started) m_started = 1;
            else if (!m_holding) begin
                if (ack) begin
                    if (br || m_redir) m_redir = 0;
                    else begin m_holding = 1; m_word = data; end
                end else if (br) begin
                    m_redir = 1; m_redir_pc = tgt;
                end
            end else if (br || rdy) m_holding = 0;
        end
    endtask

    initial begin
        Rst = 1; ImemAck = 0; ImemData = 0; InstrReady = 0; BranchTaken = 0; BranchTarget = 0;

        //            ack  data     rdy br tgt     req vld en nxt    ins
        vecs[0]  = '{1, 16'hA001, 1, 0, 8'h00, 0, 0, 0, 8'h01, 16'h0000};
        vecs[1]  = '{1, 16'hA001, 1, 0, 8'h00, 1, 0, 0, 8'h01, 16'h0000};
        vecs[2]  = '{0, 16'h0000, 1, 0, 8'h00, 0, 1, 1, 8'h01, 16'hA001};
        vecs[3]  = '{0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 8'h02, 16'hA001};
        vecs[4]  = '{0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 8'h02, 16'hA001};
        vecs[5]  = '{0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 8'h02, 16'hA001};
        vecs[6]  = '{1, 16'hB002, 0, 0, 8'h00, 1, 0, 0, 8'h02, 16'hA001};
        vecs[7]  = '{0, 16'h0000, 0, 0, 8'h00, 0, 1, 0, 8'h02, 16'hB002};
        vecs[8]  = '{0, 16'h0000, 0, 0, 8'h00, 0, 1, 0, 8'h02, 16'hB002};
        vecs[9]  = '{0, 16'h0000, 0, 0, 8'h00, 0, 1, 0, 8'h02, 16'hB002};
        vecs[10] = '{0, 16'h0000, 0, 0, 8'h00, 0, 1, 0, 8'h02, 16'hB002};
        vecs[11] = '{0, 16'h0000, 1, 0, 8'h00, 0, 1, 1, 8'h02, 16'hB002};
        vecs[12] = '{1, 16'hC003, 0, 0, 8'h00, 1, 0, 0, 8'h03, 16'hB002};
        vecs[13] = '{0, 16'h0000, 1, 1, 8'h40, 0, 0, 1, 8'h40, 16'hC003};
        vecs[14] = '{0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 8'h41, 16'hC003};
        vecs[15] = '{0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 8'h41, 16'hC003};
        vecs[16] = '{0, 16'h0000, 0, 1, 8'h20, 1, 0, 0, 8'h41, 16'hC003};
        vecs[17] = '{0, 16'h0000, 0, 1, 8'h30, 1, 0, 0, 8'h41, 16'hC003};
        vecs[18] = '{1, 16'hDEAD, 0, 0, 8'h00, 1, 0, 1, 8'h30, 16'hC003};
        vecs[19] = '{1, 16'h1234, 0, 1, 8'h55, 1, 0, 1, 8'h55, 16'hC003};
        vecs[20] = '{1, 16'h5AA5, 0, 0, 8'h00, 1, 0, 0, 8'h56, 16'hC003};
        vecs[21] = '{0, 16'h0000, 1, 0, 8'h00, 0, 1, 1, 8'h56, 16'h5AA5};
        vecs[22] = '{1, 16'h0F0F, 0, 0, 8'h00, 1, 0, 0, 8'h57, 16'h5AA5};
        vecs[23] = '{0, 16'h0000, 0, 1, 8'hFF, 0, 0, 1, 8'hFF, 16'h0F0F};
        vecs[24] = '{1, 16'h7777, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'h0F0F};
        vecs[25] = '{0, 16'h0000, 1, 0, 8'h00, 0, 1, 1, 8'h00, 16'h7777};
        vecs[26] = '{0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 8'h01, 16'h7777};

        do_reset("reset");
        for (int i = 0; i < 27; i++) begin
            drive(1'b0, vecs[i].ack, vecs[i].data, vecs[i].rdy, vecs[i].br, vecs[i].tgt);
            check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].vld, vecs[i].en,
                       vecs[i].nxt, vecs[i].ins, 1'b0);
        end

        // Redirect in IDLE is ignored; a mid-fetch reset clears the pending flush.
        do_reset("reset2");
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 8'h99);
        check_outs("idle_br", 1'b0, 1'b0, 1'b0, 8'h01, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h00);
        check_outs("idle_br_fetch", 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 8'h77);
        check_outs("pend_set", 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000, 1'b0);
        do_reset("midop_reset");
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h00);
        check_outs("midop_idle", 1'b0, 1'b0, 1'b0, 8'h01, 16'h0000, 1'b0);
        drive(1'b0, 1'b1, 16'h4242, 1'b0, 1'b0, 8'h00);
        check_outs("flush_cleared", 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h00);
        check_outs("flush_cleared_issue", 1'b0, 1'b1, 1'b0, 8'h01, 16'h4242, 1'b0);

        // Memory never answers.
        do_reset("reset3");
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h00);
`ifdef FETCH_TIMEOUT_EN
        begin
            logic seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h00);
                if (InstrValid) begin seen = 1; break; end
            end
            check("timeout_seen", {31'd0, seen}, 32'd1);
            check("timeout_nop", {16'd0, Instr}, 32'h0);
            check("timeout_err", {31'd0, FetchErr}, 32'd1);
            drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'h00);
            drive(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 8'h00);
            check("timeout_err_sticky", {31'd0, FetchErr}, 32'd1);
            do_reset("timeout_reset");
        end
`else
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'h00);
            check($sformatf("noack%0d.req", i), {31'd0, ImemReq}, 32'd1);
            check($sformatf("noack%0d.err", i), {31'd0, FetchErr}, 32'd0);
        end
        check("noack.pc", {24'd0, PCOut}, 32'h0);
        do_reset("reset4");
`endif

        // Randomized traffic against the reference model (starts with Rst high).
        model_reset();
        begin
            int streak;
            streak = 0;
            for (int i = 0; i < 3000; i++) begin
                logic r, a, rd, b;
                logic [15:0] d;
                logic [7:0] t;
                r  = ($urandom_range(0, 99) == 0);
                a  = ($urandom_range(0, 9) < 6);
                if (streak >= 10) a = 1;
                streak = a ? 0 : streak + 1;
                rd = ($urandom_range(0, 9) < 6);
                b  = ($urandom_range(0, 9) < 2);
                d  = 16'($urandom);
                t  = 8'($urandom);
                drive(r, a, d, rd, b, t);
                model_cycle(r, a, d, rd, b, t);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
